uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Framed UART boot loader: SYNC, LEN, N little-endian words into ICCM, then a checksum and an ACK/NAK reply.
// Optional inter-byte timeout enabled by defining UART_BOOT_LOADER_TIMEOUT_EN.
module uart_boot_loader #(
    parameter int unsigned AW          = 12,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic          hold_rst_o,
    output logic          done_o,
    output logic          err_o,
    output logic          tx_valid_o,
    output logic [7:0]    tx_byte_o,
    input  logic          tx_ready_i
);

    localparam int unsigned LW = 16;
    localparam int unsigned CW = LW + 1;
    localparam logic [7:0]    ACK   = 8'h06;
    localparam logic [7:0]    NAK   = 8'h15;
    localparam logic [CW-1:0] MAX_N = CW'(1) << AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [23:0]   word_q, word_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          txv_q, txv_d;
    logic [7:0]    txb_q, txb_d;

    logic [CW-1:0] n_c;
    logic [CW-1:0] wcnt_inc_c;
    logic [7:0]    sum_c;

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign hold_rst_o = hold_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign tx_valid_o = txv_q;
    assign tx_byte_o  = txb_q;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            word_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            txv_q    <= 1'b0;
            txb_q    <= '0;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            word_q   <= word_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            txv_q    <= txv_d;
            txb_q    <= txb_d;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = we_q ? addr_q + AW'(1) : addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        txv_d      = txv_q;
        txb_d      = txb_q;
        n_c        = {1'b0, rx_byte_i, len_lo_q};
        wcnt_inc_c = wcnt_q + CW'(1);
        sum_c      = sum_q + rx_byte_i;

        case (state_q)
            S_IDLE: begin
                if (rx_dv_i && rx_byte_i == SYNC_BYTE) begin
                    state_d = S_LEN0;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN0: begin
                if (rx_dv_i) begin
                    len_lo_d = rx_byte_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_dv_i) begin
                    len_d = {rx_byte_i, len_lo_q};
                    if (n_c == '0 || n_c > MAX_N) begin
                        err_d   = 1'b1;
                        txv_d   = 1'b1;
                        txb_d   = NAK;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_dv_i) begin
                    sum_d = sum_c;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_d[7:0]   = rx_byte_i;
                        2'd1: word_d[15:8]  = rx_byte_i;
                        2'd2: word_d[23:16] = rx_byte_i;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_byte_i, word_q};
                            wcnt_d  = wcnt_inc_c;
                            if (wcnt_inc_c == {1'b0, len_q}) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
            end
            S_CHK: begin
                if (rx_dv_i) begin
                    sum_d   = sum_c;
                    txv_d   = 1'b1;
                    state_d = S_RESP;
                    if (sum_c == 8'd0) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                        txb_d  = ACK;
                    end else begin
                        err_d = 1'b1;
                        txb_d = NAK;
                    end
                end
            end
            S_RESP: begin
                // Incoming bytes are dropped until the reply is accepted
                if (txv_q && tx_ready_i) begin
                    txv_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK} && !rx_dv_i) begin
            if (tmo_q == TIMEOUT_CYC - 32'd1) begin
                err_d   = 1'b1;
                txv_d   = 1'b1;
                txb_d   = NAK;
                state_d = S_RESP;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed, table-driven bench for uart_boot_loader: frames, replies, write stream and reset behaviour.
module tb_uart_boot_loader;

    localparam int unsigned AW = 12;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rx_dv_i;
    logic [7:0]    rx_byte_i;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          hold_rst_o;
    logic          done_o;
    logic          err_o;
    logic          tx_valid_o;
    logic [7:0]    tx_byte_o;
    logic          tx_ready_i;

    uart_boot_loader #(
        .AW          (AW),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (32'd100)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_dv_i    (rx_dv_i),
        .rx_byte_i  (rx_byte_i),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .hold_rst_o (hold_rst_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .tx_valid_o (tx_valid_o),
        .tx_byte_o  (tx_byte_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write/tx monitor sampled mid-cycle
    logic [AW+31:0] wq[$];
    int   we_long   = 0;
    int   txv_rise  = 0;
    logic we_prev   = 1'b0;
    logic txv_prev  = 1'b0;

    always @(negedge clk) begin
        if (we_o) wq.push_back({addr_o, wdata_o});
        if (we_o && we_prev) we_long++;
        if (tx_valid_o && !txv_prev) txv_rise++;
        we_prev  = we_o;
        txv_prev = tx_valid_o;
    end

    typedef struct {
        string        name;
        logic [127:0] stream;
        int           nbytes;
        int           dly;
        int           nw;
        logic [95:0]  w;
        logic         ok;
        logic [7:0]   resp;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [127:0] s, input int n,
                                input int dly, input int nw, input logic [95:0] w,
                                input logic ok);
        vec_t v;
        v.name   = nm;
        v.stream = s;
        v.nbytes = n;
        v.dly    = dly;
        v.nw     = nw;
        v.w      = w;
        v.ok     = ok;
        v.resp   = ok ? 8'h06 : 8'h15;
        return v;
    endfunction

    task automatic run_frame(input vec_t v);
        logic [AW+31:0] exp_w;
        logic [31:0]    wd;
        wq.delete();
        for (int i = 0; i < v.nbytes; i++) begin
            @(negedge clk);
            rx_dv_i   = 1'b1;
            rx_byte_i = v.stream[8*(v.nbytes-1-i) +: 8];
        end
        @(negedge clk);
        rx_dv_i = 1'b0;
        chk({v.name, " tx_valid"}, tx_valid_o, 1'b1);
        chk({v.name, " tx_byte"}, tx_byte_o, v.resp);
        chk({v.name, " done"}, done_o, v.ok);
        chk({v.name, " err"}, err_o, !v.ok);
        chk({v.name, " hold_rst"}, hold_rst_o, !v.ok);
        @(negedge clk);
        chk({v.name, " pulse_end"}, {done_o, err_o}, 2'b00);
        chk({v.name, " resp_hold"}, {tx_valid_o, tx_byte_o}, {1'b1, v.resp});
        for (int k = 0; k < v.dly; k++) begin
            rx_dv_i   = 1'b1;
            rx_byte_i = SYNC;
            @(negedge clk);
            chk({v.name, " resp_stable"}, {tx_valid_o, tx_byte_o}, {1'b1, v.resp});
        end
        rx_dv_i    = 1'b0;
        tx_ready_i = 1'b1;
        @(negedge clk);
        tx_ready_i = 1'b0;
        chk({v.name, " tx_drop"}, tx_valid_o, 1'b0);
        chk({v.name, " hold_after"}, hold_rst_o, !v.ok);
        chk({v.name, " nwrites"}, 64'(wq.size()), 64'(v.nw));
        for (int i = 0; i < wq.size() && i < v.nw; i++) begin
            wd    = v.w[32*i +: 32];
            exp_w = {AW'(i), wd};
            chk({v.name, " write"}, wq[i], exp_w);
        end
        chk({v.name, " addr_after"}, addr_o, AW'(v.nw));
    endtask

    vec_t vecs[6];
    int   txv0;
    int   cyc;

    initial begin
        rst_i      = 1'b1;
        rx_dv_i    = 1'b0;
        rx_byte_i  = 8'h00;
        tx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {we_o, addr_o, wdata_o, hold_rst_o, done_o, err_o, tx_valid_o, tx_byte_o}, '0);
        rst_i = 1'b0;

        vecs[0] = mk("ok1",    128'hA5_01_00_78_56_34_12_EC, 8, 0, 1,
                     {64'h0, 32'h12345678}, 1'b1);
        vecs[1] = mk("badchk", 128'hA5_01_00_78_56_34_12_ED, 8, 0, 1,
                     {64'h0, 32'h12345678}, 1'b0);
        vecs[2] = mk("len0",   128'hA5_00_00, 3, 0, 0, 96'h0, 1'b0);
        vecs[3] = mk("lenbig", 128'hA5_01_10, 3, 0, 0, 96'h0, 1'b0);
        vecs[4] = mk("three",  128'hA5_03_00_44_33_22_11_88_77_66_55_CC_BB_AA_99_D2, 16, 5, 3,
                     {32'h99AABBCC, 32'h55667788, 32'h11223344}, 1'b1);
        vecs[5] = mk("prefix", 128'h00_FF_A5_01_00_01_02_03_04_F6, 10, 0, 1,
                     {64'h0, 32'h04030201}, 1'b1);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset in the middle of a payload, then a clean reload
        @(negedge clk);
        rx_dv_i   = 1'b1;
        rx_byte_i = SYNC;
        @(negedge clk);
        chk("hold_rise", hold_rst_o, 1'b1);
        rx_byte_i = 8'h02;
        @(negedge clk);
        rx_byte_i = 8'h00;
        @(negedge clk);
        rx_byte_i = 8'h11;
        @(negedge clk);
        rx_byte_i = 8'h22;
        @(negedge clk);
        rx_dv_i = 1'b0;
        rst_i   = 1'b1;
        txv0    = txv_rise;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midframe_reset",
            {we_o, addr_o, wdata_o, hold_rst_o, done_o, err_o, tx_valid_o, tx_byte_o}, '0);
        repeat (5) @(negedge clk);
        chk("no_tx_after_reset", 64'(txv_rise), 64'(txv0));
        run_frame(vecs[0]);

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
        @(negedge clk);
        rx_dv_i   = 1'b1;
        rx_byte_i = SYNC;
        @(negedge clk);
        rx_byte_i = 8'h01;
        @(negedge clk);
        rx_byte_i = 8'h00;
        @(negedge clk);
        rx_dv_i = 1'b0;
        cyc     = 0;
        while (!err_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_cycles", 64'(cyc), 64'd100);
        chk("timeout_nak", {tx_valid_o, tx_byte_o}, {1'b1, 8'h15});
        tx_ready_i = 1'b1;
        @(negedge clk);
        tx_ready_i = 1'b0;
        chk("timeout_tx_drop", tx_valid_o, 1'b0);
`endif

        chk("we_width", 64'(we_long), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
